// File: rtl/key_switch_conditioner_pkg.sv
// Shared definitions for the key/switch front end of the router selector.
// Holds the default timing parameters (50 MHz board clock), the channel
// map of the five cleaned inputs and the per-key repeat FSM state type.
package key_switch_conditioner_pkg;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 50_000;      // 1 ms
  localparam int unsigned DEF_REPEAT_DELAY    = 25_000_000;  // 0.5 s
  localparam int unsigned DEF_REPEAT_PERIOD   = 5_000_000;   // 0.1 s
  localparam int unsigned DEF_CNT_W           = 26;

  localparam int unsigned NUM_CH         = 5;
  localparam int unsigned CH_SW_ON       = 0;
  localparam int unsigned CH_SW_SEL_DATA = 1;
  localparam int unsigned CH_SW_SEL_RTR  = 2;
  localparam int unsigned CH_KEY_INC     = 3;
  localparam int unsigned CH_KEY_DEC     = 4;

  typedef enum logic [1:0] {
    KEY_IDLE = 2'd0,
    KEY_HOLD = 2'd1,
    KEY_GAP  = 2'd2,
    KEY_RPT  = 2'd3
  } key_state_e;

endpackage

// File: rtl/key_switch_conditioner_debounce_cell.sv
// debounce_cell: 2-FF synchroniser followed by a stability counter.
// The accepted level only follows the synchronised input after it has
// differed from the current accepted level for DEBOUNCE_CYCLES consecutive
// cycles; any return to the accepted level restarts the count.
// Ports:
//   clk   system clock
//   rst   asynchronous reset, active-high (dout -> 0)
//   din   raw asynchronous input, active-high
//   dout  debounced level (registered)
module debounce_cell
  import key_switch_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             sync1;
  logic             sync2;
  logic             stable;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_TC) begin
        stable <= sync2;
        cnt    <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign dout = stable;

endmodule

// File: rtl/key_switch_conditioner.sv
// key_switch_conditioner: cleans the raw board inputs feeding the router
// selector. Three slide switches and two active-low push keys are
// synchronised and debounced; the keys additionally get hold-to-repeat,
// where a held key drops its output for one cycle after REPEAT_DELAY and
// then every REPEAT_PERIOD+1 cycles so the selector's edge detector fires
// again. REPEAT_PERIOD = 0 disables repeat.
//
// Key FSM:
//   state | meaning
//   IDLE  | key released, output low
//   HOLD  | pressed, waiting REPEAT_DELAY for the first repeat
//   GAP   | one-cycle low gap that re-arms the downstream edge detector
//   RPT   | pressed, waiting REPEAT_PERIOD for the next repeat
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   sw_*_raw                 raw slide switches, active-high
//   key_inc_n, key_dec_n     raw push keys, active-low
//   sw_on/sw_sel_data/sw_sel_router  debounced switch levels
//   key_inc, key_dec         debounced pressed levels with repeat gaps
//   key_inc_pulse/key_dec_pulse     one-cycle strobe on every 0->1 of key out
module key_switch_conditioner
  import key_switch_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter int unsigned CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_on_raw,
  input  logic sw_sel_data_raw,
  input  logic sw_sel_router_raw,
  input  logic key_inc_n,
  input  logic key_dec_n,
  output logic sw_on,
  output logic sw_sel_data,
  output logic sw_sel_router,
  output logic key_inc,
  output logic key_dec,
  output logic key_inc_pulse,
  output logic key_dec_pulse
);

  localparam logic [CNT_W-1:0] DELAY_TC  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_TC = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam bit               REPEAT_EN = (REPEAT_PERIOD != 0);

  logic [NUM_CH-1:0] raw_vec;
  logic [NUM_CH-1:0] stable;
  logic [1:0]        key_level;
  logic [1:0]        key_strobe;

  // Keys are inverted up front so every channel is active-high from here on.
  assign raw_vec = {~key_dec_n, ~key_inc_n, sw_sel_router_raw, sw_sel_data_raw, sw_on_raw};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_db
    debounce_cell #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_db (
      .clk  (clk),
      .rst  (rst),
      .din  (raw_vec[i]),
      .dout (stable[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_on         <= 1'b0;
      sw_sel_data   <= 1'b0;
      sw_sel_router <= 1'b0;
    end else begin
      sw_on         <= stable[CH_SW_ON];
      sw_sel_data   <= stable[CH_SW_SEL_DATA];
      sw_sel_router <= stable[CH_SW_SEL_RTR];
    end
  end

  for (genvar k = 0; k < 2; k++) begin : g_key
    key_state_e       state_q, state_d;
    logic [CNT_W-1:0] rcnt_q, rcnt_d, rcnt_inc;
    logic             out_q, out_d;
    logic             pulse_q, pulse_d;
    logic             pressed;

    assign pressed  = stable[CH_KEY_INC + k];
    assign rcnt_inc = (rcnt_q == CNT_MAX) ? rcnt_q : rcnt_q + CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= KEY_IDLE;
        rcnt_q  <= '0;
        out_q   <= 1'b0;
        pulse_q <= 1'b0;
      end else begin
        state_q <= state_d;
        rcnt_q  <= rcnt_d;
        out_q   <= out_d;
        pulse_q <= pulse_d;
      end
    end

    // out/pulse are next-state values so the registered strobe lines up
    // exactly with the registered 0->1 of the key level.
    always_comb begin
      state_d = state_q;
      rcnt_d  = rcnt_q;
      out_d   = 1'b0;
      pulse_d = 1'b0;
      case (state_q)
        KEY_IDLE: begin
          if (pressed) begin
            state_d = KEY_HOLD;
            rcnt_d  = '0;
            out_d   = 1'b1;
            pulse_d = 1'b1;
          end
        end
        KEY_HOLD: begin
          if (!pressed) begin
            state_d = KEY_IDLE;
            rcnt_d  = '0;
          end else if (REPEAT_EN && rcnt_q == DELAY_TC) begin
            state_d = KEY_GAP;
            rcnt_d  = '0;
          end else begin
            out_d  = 1'b1;
            rcnt_d = rcnt_inc;
          end
        end
        KEY_GAP: begin
          if (!pressed) begin
            state_d = KEY_IDLE;
          end else begin
            state_d = KEY_RPT;
            out_d   = 1'b1;
            pulse_d = 1'b1;
          end
          rcnt_d = '0;
        end
        KEY_RPT: begin
          if (!pressed) begin
            state_d = KEY_IDLE;
            rcnt_d  = '0;
          end else if (rcnt_q == PERIOD_TC) begin
            state_d = KEY_GAP;
            rcnt_d  = '0;
          end else begin
            out_d  = 1'b1;
            rcnt_d = rcnt_inc;
          end
        end
        default: begin
          state_d = KEY_IDLE;
          rcnt_d  = '0;
        end
      endcase
    end

    assign key_level[k]  = out_q;
    assign key_strobe[k] = pulse_q;
  end

  assign key_inc       = key_level[0];
  assign key_dec       = key_level[1];
  assign key_inc_pulse = key_strobe[0];
  assign key_dec_pulse = key_strobe[1];

endmodule

// File: tb/tb_key_switch_conditioner.sv
// Bench for key_switch_conditioner. A reference model runs alongside the
// DUT: debounce is a window test over the raw sample history and the key
// output is derived arithmetically from how long the debounced key has been
// held. Directed phases measure latency, pulse counts and gap positions.
module tb_key_switch_conditioner;

  localparam int unsigned P_DB = 4;
  localparam int unsigned P_RD = 20;
  localparam int unsigned P_RP = 8;
  localparam int unsigned P_CW = 8;

  logic clk, rst;
  logic sw_on_raw, sw_sel_data_raw, sw_sel_router_raw, key_inc_n, key_dec_n;
  logic sw_on, sw_sel_data, sw_sel_router, key_inc, key_dec, key_inc_pulse, key_dec_pulse;

  key_switch_conditioner #(
    .DEBOUNCE_CYCLES (P_DB),
    .REPEAT_DELAY    (P_RD),
    .REPEAT_PERIOD   (P_RP),
    .CNT_W           (P_CW)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .sw_on_raw         (sw_on_raw),
    .sw_sel_data_raw   (sw_sel_data_raw),
    .sw_sel_router_raw (sw_sel_router_raw),
    .key_inc_n         (key_inc_n),
    .key_dec_n         (key_dec_n),
    .sw_on             (sw_on),
    .sw_sel_data       (sw_sel_data),
    .sw_sel_router     (sw_sel_router),
    .key_inc           (key_inc),
    .key_dec           (key_dec),
    .key_inc_pulse     (key_inc_pulse),
    .key_dec_pulse     (key_dec_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // ---------------- reference model ----------------
  int unsigned m_hist[5];
  bit          m_stable[5];
  bit          m_sw[3];
  bit          m_kout[2];
  bit          m_kpulse[2];
  int          held[2];
  int          cyc = 0;

  localparam int unsigned WIN_MASK = (1 << P_DB) - 1;

  task automatic model_reset();
    for (int c = 0; c < 5; c++) begin
      m_hist[c]   = 0;
      m_stable[c] = 1'b0;
    end
    for (int c = 0; c < 3; c++) m_sw[c] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_kout[k]   = 1'b0;
      m_kpulse[k] = 1'b0;
      held[k]     = -1;
    end
  endtask

  task automatic model_step();
    bit raw[5];
    bit gap;
    int unsigned win;
    raw[0] = sw_on_raw;
    raw[1] = sw_sel_data_raw;
    raw[2] = sw_sel_router_raw;
    raw[3] = !key_inc_n;
    raw[4] = !key_dec_n;
    for (int c = 0; c < 3; c++) m_sw[c] = m_stable[c];
    for (int k = 0; k < 2; k++) begin
      if (!m_stable[3+k]) begin
        held[k]     = -1;
        m_kout[k]   = 1'b0;
        m_kpulse[k] = 1'b0;
      end else begin
        held[k]++;
        gap = (P_RP != 0) && (held[k] >= int'(P_RD)) &&
              ((held[k] - int'(P_RD)) % int'(P_RP + 1) == 0);
        m_kout[k]   = !gap;
        m_kpulse[k] = (held[k] == 0) ||
                      ((P_RP != 0) && (held[k] > int'(P_RD)) &&
                       ((held[k] - int'(P_RD) - 1) % int'(P_RP + 1) == 0));
      end
    end
    // Accept a new level once the last P_DB synchronised samples (two
    // cycles behind the pins) all disagree with the current level.
    for (int c = 0; c < 5; c++) begin
      win = (m_hist[c] >> 1) & WIN_MASK;
      if (win == (m_stable[c] ? 0 : WIN_MASK)) m_stable[c] = !m_stable[c];
      m_hist[c] = (m_hist[c] << 1) | int'(raw[c]);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (rst) model_reset();
    else     model_step();
  end

  // ---------------- observation ----------------
  int n_inc_pulse, n_dec_pulse, first_inc_cyc, first_dec_cyc;
  int n_dec_falls, last_dec_fall, n_sw_rises, sw_rise_cyc;
  int dec_pulse_q[$];
  bit prev_dec, prev_sw;

  task automatic clear_stats();
    n_inc_pulse   = 0;
    n_dec_pulse   = 0;
    first_inc_cyc = -1;
    first_dec_cyc = -1;
    n_dec_falls   = 0;
    last_dec_fall = -1;
    n_sw_rises    = 0;
    sw_rise_cyc   = -1;
    dec_pulse_q.delete();
    prev_dec = key_dec;
    prev_sw  = sw_on;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("sw_on",         sw_on,         m_sw[0]);
      chk("sw_sel_data",   sw_sel_data,   m_sw[1]);
      chk("sw_sel_router", sw_sel_router, m_sw[2]);
      chk("key_inc",       key_inc,       m_kout[0]);
      chk("key_dec",       key_dec,       m_kout[1]);
      chk("key_inc_pulse", key_inc_pulse, m_kpulse[0]);
      chk("key_dec_pulse", key_dec_pulse, m_kpulse[1]);
      if (key_inc_pulse) begin
        n_inc_pulse++;
        if (first_inc_cyc < 0) first_inc_cyc = cyc;
      end
      if (key_dec_pulse) begin
        n_dec_pulse++;
        dec_pulse_q.push_back(cyc);
        if (first_dec_cyc < 0) first_dec_cyc = cyc;
      end
      if (prev_dec && !key_dec) begin
        n_dec_falls++;
        last_dec_fall = cyc;
      end
      if (!prev_sw && sw_on) begin
        n_sw_rises++;
        sw_rise_cyc = cyc;
      end
      prev_dec = key_dec;
      prev_sw  = sw_on;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sw_on"},     sw_on,         0);
    chk({tag, "_sw_data"},   sw_sel_data,   0);
    chk({tag, "_sw_rtr"},    sw_sel_router, 0);
    chk({tag, "_key_inc"},   key_inc,       0);
    chk({tag, "_key_dec"},   key_dec,       0);
    chk({tag, "_inc_pulse"}, key_inc_pulse, 0);
    chk({tag, "_dec_pulse"}, key_dec_pulse, 0);
  endtask

  localparam int LAT = P_DB + 2;

  int e, r, last_edge;
  bit drv[5];
  int hold_left[5];

  initial begin
    rst = 1'b1;
    sw_on_raw = 1'b0; sw_sel_data_raw = 1'b0; sw_sel_router_raw = 1'b0;
    key_inc_n = 1'b1; key_dec_n = 1'b1;

    // Reset state and quiet period after release
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    clear_stats();
    run(50);
    chk("post_reset_pulses", n_inc_pulse + n_dec_pulse, 0);

    // Clean press of key_inc held for 10 cycles
    clear_stats();
    key_inc_n = 1'b0; e = cyc + 1;
    run(10);
    key_inc_n = 1'b1;
    run(15);
    chk("press_latency", first_inc_cyc - e, LAT);
    chk("press_pulses", n_inc_pulse, 1);

    // Bounce on sw_on shorter than the debounce window, then settle high
    clear_stats();
    for (int t = 0; t < 10; t++) begin
      sw_on_raw = ~sw_on_raw;
      run(2);
    end
    sw_on_raw = 1'b1; last_edge = cyc + 1;
    run(12);
    chk("bounce_rise_latency", sw_rise_cyc - last_edge, LAT);
    chk("bounce_rises", n_sw_rises, 1);
    sw_on_raw = 1'b0;
    run(10);

    // Auto-repeat on key_dec
    clear_stats();
    key_dec_n = 1'b0; e = cyc + 1;
    run(55);
    key_dec_n = 1'b1; r = cyc + 1;
    run(12);
    chk("rpt_first_latency", first_dec_cyc - e, LAT);
    chk("rpt_pulses", n_dec_pulse, 5);
    chk("rpt_falls", n_dec_falls, 5);
    chk("rpt_release_latency", last_dec_fall - r, LAT);
    if (dec_pulse_q.size() >= 3) begin
      chk("rpt_first_repeat", dec_pulse_q[1] - dec_pulse_q[0], P_RD + 1);
      chk("rpt_period", dec_pulse_q[2] - dec_pulse_q[1], P_RP + 1);
    end else begin
      chk("rpt_pulse_queue", dec_pulse_q.size(), 3);
    end

    // Both keys pressed on the same edge
    clear_stats();
    key_inc_n = 1'b0; key_dec_n = 1'b0; e = cyc + 1;
    run(30);
    key_inc_n = 1'b1; key_dec_n = 1'b1;
    run(12);
    chk("simul_inc_latency", first_inc_cyc - e, LAT);
    chk("simul_dec_latency", first_dec_cyc - e, LAT);
    chk("simul_inc_pulses", n_inc_pulse, 2);
    chk("simul_dec_pulses", n_dec_pulse, 2);

    // Reset while repeating with the key still held
    clear_stats();
    key_inc_n = 1'b0;
    run(40);
    rst = 1'b1;
    #1;
    chk_all_zero("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    clear_stats();
    e = cyc + 1;
    run(12);
    chk("rearm_latency", first_inc_cyc - e, LAT);
    chk("rearm_pulses", n_inc_pulse, 1);
    key_inc_n = 1'b1;
    run(12);

    // Randomised inputs with occasional resets, model in lockstep
    for (int c = 0; c < 5; c++) begin
      drv[c] = 1'b0;
      hold_left[c] = 1;
    end
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < 5; c++) begin
        hold_left[c]--;
        if (hold_left[c] <= 0) begin
          drv[c] = ~drv[c];
          hold_left[c] = (c >= 3) ? int'($urandom_range(1, 45)) : int'($urandom_range(1, 10));
        end
      end
      sw_on_raw = drv[0]; sw_sel_data_raw = drv[1]; sw_sel_router_raw = drv[2];
      key_inc_n = !drv[3]; key_dec_n = !drv[4];
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b1;
        run(1);
        rst = 1'b0;
      end else begin
        run(1);
      end
    end
    sw_on_raw = 1'b0; sw_sel_data_raw = 1'b0; sw_sel_router_raw = 1'b0;
    key_inc_n = 1'b1; key_dec_n = 1'b1;
    run(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
